pol2rec: RTL and testbench

Iterative CORDIC polar-to-rectangular converter (rotation mode), the inverse of the rec2pol vectoring unit. It takes an unsigned modulus and a signed angle in degrees, using the same Q10 angle format as rec2pol, and produces mod·cos(angle) and mod·sin(angle) as signed integers. It uses the same start/busy handshake as rec2pol so a controller can drive either unit, and adds a one-cycle done strobe.

---
 rtl/pol2rec.sv | 160 ++++++++++++++++
 tb/tb_pol2rec.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pol2rec.sv
// Iterative CORDIC polar-to-rectangular converter (rotation mode).
// Latches mod/angle on start, then LOAD, 16 micro-rotations, and OUTPUT with a one-cycle done strobe.
module pol2rec #(
    parameter int ITER = 16,
    parameter int FRAC = 6
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic        [15:0] mod_i,
    input  logic signed [18:0] angle_i,
    output logic               busy_o,
    output logic               done_o,
    output logic signed [17:0] x_o,
    output logic signed [17:0] y_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ROTATE,
        S_OUTPUT
    } state_t;

    localparam logic signed [19:0] DEG90  = 20'sd92160;
    localparam logic signed [19:0] DEG180 = 20'sd184320;
    localparam logic signed [19:0] DEG360 = 20'sd368640;
    localparam logic signed [23:0] RND    = 24'sd1 <<< (FRAC - 1);

    state_t             state_q;
    logic               busy_q, done_q;
    logic        [3:0]  iter_q;
    logic        [15:0] mod_q;
    logic signed [18:0] angle_q;
    logic signed [23:0] x_q, y_q;
    logic signed [19:0] z_q;
    logic signed [17:0] xo_q, yo_q;

    logic        [31:0] prod_d;
    logic signed [23:0] xi_d, x_load_d, x_sh_d, y_sh_d, x_rot_d, y_rot_d, x_rnd_d, y_rnd_d;
    logic signed [19:0] ang_ext_d, ang_wrap_d, z_load_d, atan_d, z_rot_d;

    function automatic logic signed [19:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = 20'sd46080;
            4'd1:    atan_lut = 20'sd27203;
            4'd2:    atan_lut = 20'sd14373;
            4'd3:    atan_lut = 20'sd7296;
            4'd4:    atan_lut = 20'sd3662;
            4'd5:    atan_lut = 20'sd1833;
            4'd6:    atan_lut = 20'sd917;
            4'd7:    atan_lut = 20'sd458;
            4'd8:    atan_lut = 20'sd229;
            4'd9:    atan_lut = 20'sd115;
            4'd10:   atan_lut = 20'sd57;
            4'd11:   atan_lut = 20'sd29;
            4'd12:   atan_lut = 20'sd14;
            4'd13:   atan_lut = 20'sd7;
            4'd14:   atan_lut = 20'sd4;
            default: atan_lut = 20'sd2;
        endcase
    endfunction

    always_comb begin
        // Gain pre-compensation: 39797/65536 ~ 1/1.64676, result lands in Q(FRAC)
        prod_d    = {16'd0, mod_q} * 32'd39797;
        xi_d      = $signed(24'(prod_d >> (16 - FRAC)));
        ang_ext_d = {angle_q[18], angle_q};

        ang_wrap_d = ang_ext_d;
        if (ang_ext_d > DEG180)
            ang_wrap_d = ang_ext_d - DEG360;
        else if (ang_ext_d < -DEG180)
            ang_wrap_d = ang_ext_d + DEG360;

        // Fold into +/-90 deg by starting from the negated vector
        z_load_d = ang_wrap_d;
        x_load_d = xi_d;
        if (ang_wrap_d > DEG90) begin
            z_load_d = ang_wrap_d - DEG180;
            x_load_d = -xi_d;
        end else if (ang_wrap_d < -DEG90) begin
            z_load_d = ang_wrap_d + DEG180;
            x_load_d = -xi_d;
        end

        x_sh_d = x_q >>> iter_q;
        y_sh_d = y_q >>> iter_q;
        atan_d = atan_lut(iter_q);
        if (!z_q[19]) begin
            x_rot_d = x_q - y_sh_d;
            y_rot_d = y_q + x_sh_d;
            z_rot_d = z_q - atan_d;
        end else begin
            x_rot_d = x_q + y_sh_d;
            y_rot_d = y_q - x_sh_d;
            z_rot_d = z_q + atan_d;
        end

        x_rnd_d = x_q + RND;
        y_rnd_d = y_q + RND;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            iter_q  <= 4'd0;
            mod_q   <= 16'd0;
            angle_q <= 19'sd0;
            x_q     <= 24'sd0;
            y_q     <= 24'sd0;
            z_q     <= 20'sd0;
            xo_q    <= 18'sd0;
            yo_q    <= 18'sd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mod_q   <= mod_i;
                        angle_q <= angle_i;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    x_q     <= x_load_d;
                    y_q     <= 24'sd0;
                    z_q     <= z_load_d;
                    iter_q  <= 4'd0;
                    state_q <= S_ROTATE;
                end
                S_ROTATE: begin
                    x_q    <= x_rot_d;
                    y_q    <= y_rot_d;
                    z_q    <= z_rot_d;
                    iter_q <= iter_q + 4'd1;
                    if (iter_q == 4'(ITER - 1))
                        state_q <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    xo_q    <= 18'(x_rnd_d >>> FRAC);
                    yo_q    <= 18'(y_rnd_d >>> FRAC);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign x_o    = xo_q;
    assign y_o    = yo_q;

endmodule

// File: tb/tb_pol2rec.sv
// Directed-vector bench for pol2rec: table of polar inputs with hand-computed results,
// plus handshake, back-to-back, reset-abort and a 15-degree sweep against real cos/sin.
module tb_pol2rec;

    logic               clk_i = 1'b0;
    logic               rst_n_i = 1'b0;
    logic               start_i = 1'b0;
    logic        [15:0] mod_i = 16'd0;
    logic signed [18:0] angle_i = 19'sd0;
    logic               busy_o, done_o;
    logic signed [17:0] x_o, y_o;

    int tests = 0;
    int fails = 0;

    pol2rec dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .start_i (start_i),
        .mod_i   (mod_i),
        .angle_i (angle_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .x_o     (x_o),
        .y_o     (y_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        [15:0] m;
        logic signed [18:0] a;
        int                 ex;
        int                 ey;
        int                 tol;
    } vec_t;

    vec_t vecs[10];

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        int d;
        tests++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d +/-%0d", name, act, exp, tol);
        end
    endtask

    // Issue one start pulse and wait (bounded) for done; lat = edges from start to done, -1 on timeout.
    task automatic convert(input logic [15:0] m, input logic signed [18:0] a,
                           output int xr, output int yr, output int lat);
        mod_i   = m;
        angle_i = a;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_i); #1;
            if (done_o) begin
                lat = k;
                break;
            end
        end
        xr = int'(x_o);
        yr = int'(y_o);
    endtask

    int xr, yr, lat, ndone, first_done, second_done, third_done;
    real pi, rad, ex_r, ey_r, ang_r, diff;

    initial begin
        pi = 3.14159265358979;
        vecs[0] = '{16'd4096,  19'sd0,       4096,  0,     2};
        vecs[1] = '{16'd4096,  19'sd92160,   0,     4096,  2};
        vecs[2] = '{16'd4095, -19'sd138240, -2896, -2896,  2};
        vecs[3] = '{16'd1000,  19'sd184320, -1000,  0,     2};
        vecs[4] = '{16'd1000, -19'sd250880, -423,   906,   2};
        vecs[5] = '{16'd65535, 19'sd46080,   46341, 46341, 3};
        vecs[6] = '{16'd0,     19'sd12345,   0,     0,     0};
        vecs[7] = '{16'd0,    -19'sd200000,  0,     0,     0};
        vecs[8] = '{16'd2000,  19'sd30720,   1732,  1000,  2};
        vecs[9] = '{16'd3000, -19'sd61440,   1500, -2598,  2};

        #3;
        check_tol("reset_busy", int'(busy_o), 0, 0);
        check_tol("reset_done", int'(done_o), 0, 0);
        check_tol("reset_x", int'(x_o), 0, 0);
        check_tol("reset_y", int'(y_o), 0, 0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i); #1;
        end
        check_tol("no_start_after_reset", int'(busy_o), 0, 0);

        for (int i = 0; i < 10; i++) begin
            convert(vecs[i].m, vecs[i].a, xr, yr, lat);
            check_tol($sformatf("vec%0d_latency", i), lat, 18, 0);
            check_tol($sformatf("vec%0d_x", i), xr, vecs[i].ex, vecs[i].tol);
            check_tol($sformatf("vec%0d_y", i), yr, vecs[i].ey, vecs[i].tol);
            check_tol($sformatf("vec%0d_busy_at_done", i), int'(busy_o), 0, 0);
        end
        @(posedge clk_i); #1;
        check_tol("done_one_cycle", int'(done_o), 0, 0);

        // Second start during busy must be ignored
        mod_i = 16'd4096; angle_i = 19'sd0; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            check_tol($sformatf("hs_busy_k%0d", k), int'(busy_o), (k <= 17) ? 1 : 0, 0);
            if (done_o) begin
                ndone++;
                check_tol("hs_done_cycle", k, 18, 0);
                check_tol("hs_x", int'(x_o), 4096, 2);
                check_tol("hs_y", int'(y_o), 0, 2);
            end
            start_i = (k == 4);
            if (k == 4) begin
                mod_i = 16'd1000; angle_i = 19'sd92160;
            end
            @(posedge clk_i); #1;
        end
        start_i = 1'b0;
        check_tol("hs_done_count", ndone, 1, 0);

        // Held start: conversions repeat every 19 cycles
        mod_i = 16'd2000; angle_i = 19'sd30720; start_i = 1'b1;
        first_done = -1; second_done = -1; third_done = -1;
        for (int k = 0; k < 80; k++) begin
            @(posedge clk_i); #1;
            if (done_o) begin
                if (first_done < 0) first_done = k;
                else if (second_done < 0) second_done = k;
                else if (third_done < 0) third_done = k;
            end
        end
        start_i = 1'b0;
        check_tol("b2b_first", first_done, 18, 0);
        check_tol("b2b_period1", second_done - first_done, 19, 0);
        check_tol("b2b_period2", third_done - second_done, 19, 0);
        for (int k = 0; k < 25; k++) begin
            @(posedge clk_i); #1;
        end

        // Reset mid-conversion clears everything without waiting for an edge
        convert(16'd4096, 19'sd0, xr, yr, lat);
        mod_i = 16'd1000; angle_i = 19'sd46080; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_i); #1;
        end
        check_tol("abort_busy_before", int'(busy_o), 1, 0);
        #2 rst_n_i = 1'b0;
        #1;
        check_tol("abort_busy", int'(busy_o), 0, 0);
        check_tol("abort_done", int'(done_o), 0, 0);
        check_tol("abort_x", int'(x_o), 0, 0);
        check_tol("abort_y", int'(y_o), 0, 0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        ndone = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) ndone++;
        end
        check_tol("abort_no_resume", ndone, 0, 0);
        convert(16'd1000, 19'sd46080, xr, yr, lat);
        check_tol("post_reset_latency", lat, 18, 0);
        check_tol("post_reset_x", xr, 707, 2);
        check_tol("post_reset_y", yr, 707, 2);

        // Sweep -180..+180 deg in 15 deg steps at mod=3072
        for (int d = -180; d <= 180; d += 15) begin
            convert(16'd3072, 19'(d * 1024), xr, yr, lat);
            rad  = real'(d) * pi / 180.0;
            ex_r = $floor(3072.0 * $cos(rad) + 0.5);
            ey_r = $floor(3072.0 * $sin(rad) + 0.5);
            check_tol($sformatf("sweep%0d_x", d), xr, int'(ex_r), 2);
            check_tol($sformatf("sweep%0d_y", d), yr, int'(ey_r), 2);
            ang_r = $atan2(real'(yr), real'(xr)) * 180.0 / pi;
            diff  = ang_r - real'(d);
            if (diff > 180.0) diff = diff - 360.0;
            if (diff < -180.0) diff = diff + 360.0;
            check_tol($sformatf("sweep%0d_angle_mdeg", d), int'(diff * 1000.0), 0, 100);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
